// File: rtl/aes_pkg.sv
// AES-128 key-expansion shared types, constants and helpers.
// Used by key_expand_ctrl and key_g_word. Optional macro KEY_STORE_EN is handled in the top.
package aes_pkg;

    // FSM encoding kept as plain constants for compatibility with older tooling
    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t EMIT = 1'b1;

    localparam int unsigned AES_NR_MAX = 10;
    localparam logic [7:0]  RCON_INIT  = 8'h01;

    // word_t[row]: row 0 is the most significant byte of a 32-bit column word
    typedef logic [0:3][7:0]       word_t;
    // key_t[row][col]: col selects the 32-bit word
    typedef logic [0:3][0:3][7:0]  key_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // GF(2^8) multiply by x, used to step Rcon
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/key_g_word.sv
// Combinational g-word for AES-128 key expansion: RotWord, SubWord, then Rcon on byte 0.
module key_g_word
    import aes_pkg::*;
(
    input  word_t      w3,
    input  logic [7:0] rcon,
    output word_t      g
);

    // Rotate up by one byte while substituting
    assign g[0] = SBOX[w3[1]] ^ rcon;
    assign g[1] = SBOX[w3[2]];
    assign g[2] = SBOX[w3[3]];
    assign g[3] = SBOX[w3[0]];

endmodule

// File: rtl/key_expand_ctrl.sv
// AES-128 key-expansion sequencer: latches the cipher key and hands out round keys 0..NR,
// one per valid/ready handshake. Define KEY_STORE_EN to add a readable round-key store.
module key_expand_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NR = AES_NR_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  key_t       key_in,
    input  logic       abort,
    output key_t       rk_out,
    output logic [3:0] rk_idx,
    output logic       rk_valid,
    input  logic       rk_ready,
    output logic       busy,
    output logic       done
`ifdef KEY_STORE_EN
    ,
    input  logic [3:0] rd_idx,
    output key_t       rd_key,
    output logic       rd_key_ok
`endif
);

    localparam logic [3:0] NR_IDX = 4'(NR);

    state_t     state_q, state_d;
    key_t       rk_q, rk_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] rcon_q, rcon_d;
    logic       done_q, done_d;

    word_t      w3;
    word_t      g;
    key_t       rk_next;
    logic       start_ok;
    logic       hs;

    // Abort wins over both a same-cycle start and a same-cycle handshake
    assign start_ok = (state_q == IDLE) && start && !abort;
    assign hs       = (state_q == EMIT) && rk_ready && !abort;

    // Pick out word 3 (column 3) of the current key
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            w3[r] = rk_q[r][3];
        end
    end

    key_g_word u_g_word (
        .w3   (w3),
        .rcon (rcon_q),
        .g    (g)
    );

    // KeyXor datapath: chain each new word off the previous new word
    always_comb begin : key_xor
        for (int r = 0; r < 4; r++) begin
            rk_next[r][0] = rk_q[r][0] ^ g[r];
            rk_next[r][1] = rk_q[r][1] ^ rk_next[r][0];
            rk_next[r][2] = rk_q[r][2] ^ rk_next[r][1];
            rk_next[r][3] = rk_q[r][3] ^ rk_next[r][2];
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = EMIT;
                    rk_d    = key_in;
                    idx_d   = 4'd0;
                    rcon_d  = RCON_INIT;
                end
            end
            EMIT: begin
                if (abort) begin
                    state_d = IDLE;
                    rcon_d  = RCON_INIT;
                end else if (hs) begin
                    if (idx_q == NR_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        rk_d   = rk_next;
                        idx_d  = idx_q + 4'd1;
                        rcon_d = xtime(rcon_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rk_q    <= '0;
            idx_q   <= 4'd0;
            rcon_q  <= RCON_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    assign rk_out   = rk_q;
    assign rk_idx   = idx_q;
    assign rk_valid = (state_q == EMIT);
    assign busy     = (state_q == EMIT);
    assign done     = done_q;

`ifdef KEY_STORE_EN
    key_t      store_q [NR+1];
    logic [NR:0] written_q;

    // Track which entries hold a key from the current expansion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_q <= '0;
        end else if (start_ok || ((state_q == EMIT) && abort)) begin
            written_q <= '0;
        end else if (hs) begin
            written_q[idx_q] <= 1'b1;
        end
    end

    // Capture each key as it is handed over
    always_ff @(posedge clk) begin
        if (hs) begin
            store_q[idx_q] <= rk_q;
        end
    end

    assign rd_key_ok = (rd_idx <= NR_IDX) && written_q[rd_idx];
    assign rd_key    = (rd_idx <= NR_IDX) ? store_q[rd_idx] : '0;
`endif

endmodule
